// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: writes N_WORDS seeded words through a wb_master request port, reads them back and checks them.
// Ports:
//   clk_i, rstn_i                   clock, asynchronous active-low reset
//   start_i                         start pulse, accepted in IDLE or DONE
//   busy_o, done_o, pass_o          run status
//   err_cnt_o, timeout_o            saturating mismatch count, response timeout flag
//   req_data_o .. req_valid_o       request to master (data/addr/n_access/we/valid)
//   rsp_valid_i, rsp_data_i         response from master
//   err_addr_o, err_exp_o, err_got_o first-mismatch log, present only with WB_TRAFFIC_GEN_ERRLOG_EN
module wb_traffic_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          N_WORDS   = 4,
    parameter logic [31:0] SEED      = 32'hACE1ACE1,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [7:0]  err_cnt_o,
    output logic        timeout_o,
    output logic [31:0] req_data_o,
    output logic [31:0] req_addr_o,
    output logic [2:0]  req_naccess_o,
    output logic [3:0]  req_we_o,
    output logic        req_valid_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
    ,
    output logic [31:0] err_addr_o,
    output logic [31:0] err_exp_o,
    output logic [31:0] err_got_o
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WGAP, S_READ, S_RGAP, S_DONE} state_t;
    state_t      r_state, w_state_nxt;
    logic [7:0]  r_idx, w_idx_nxt, r_err, w_err_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic        r_tmo, w_tmo_nxt;
    logic        w_start, w_last, w_expire, w_mis, w_valid, w_wr;
    function automatic logic [31:0] pattern(input logic [7:0] i);
        return SEED + 32'(i) * 32'h9E3779B9;
    endfunction
    assign w_start  = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = r_idx == 8'(N_WORDS - 1);
    // expires on the TIMEOUT-th consecutive waiting cycle; a response in that cycle still wins
    assign w_expire = !rsp_valid_i && r_timer == 16'(TIMEOUT - 1);
    assign w_mis    = r_state == S_READ && rsp_valid_i && rsp_data_i != pattern(r_idx);
    assign err_cnt_o = r_err;
    assign timeout_o = r_tmo;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_err         <= '0;
            r_tmo         <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            req_valid_o   <= 1'b0;
            req_addr_o    <= '0;
            req_data_o    <= '0;
            req_we_o      <= '0;
            req_naccess_o <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_err         <= w_err_nxt;
            r_tmo         <= w_tmo_nxt;
            busy_o        <= w_valid;
            done_o        <= w_state_nxt == S_DONE;
            pass_o        <= w_state_nxt == S_DONE && w_err_nxt == 8'd0 && !w_tmo_nxt;
            req_valid_o   <= w_valid;
            req_addr_o    <= w_valid ? BASE_ADDR + {22'd0, w_idx_nxt, 2'b00} : 32'd0;
            req_data_o    <= w_wr ? pattern(w_idx_nxt) : 32'd0;
            req_we_o      <= w_wr ? 4'hF : 4'h0;
            req_naccess_o <= w_valid ? 3'd4 : 3'd0;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_timer_nxt = r_timer;
        w_err_nxt   = r_err;
        w_tmo_nxt   = r_tmo;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) begin
                w_state_nxt = S_WRITE;
                w_idx_nxt   = '0;
                w_timer_nxt = '0;
                w_err_nxt   = '0;
                w_tmo_nxt   = 1'b0;
            end
            S_WRITE, S_READ: if (rsp_valid_i) begin
                w_timer_nxt = '0;
                w_err_nxt   = (w_mis && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
                w_idx_nxt   = w_last ? 8'd0 : r_idx + 8'd1;
                w_state_nxt = r_state == S_WRITE ? (w_last ? S_RGAP : S_WGAP) : (w_last ? S_DONE : S_RGAP);
            end else if (w_expire) begin
                w_state_nxt = S_DONE;
                w_tmo_nxt   = 1'b1;
            end else
                w_timer_nxt = r_timer + 16'd1;
            S_WGAP:  w_state_nxt = S_WRITE;
            S_RGAP:  w_state_nxt = S_READ;
            default: w_state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        w_valid = w_state_nxt == S_WRITE || w_state_nxt == S_READ;
        w_wr    = w_state_nxt == S_WRITE;
    end
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
    // only the first mismatch of a run is kept: r_err is still zero exactly then
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_addr_o <= '0;
            err_exp_o  <= '0;
            err_got_o  <= '0;
        end else if (w_start) begin
            err_addr_o <= '0;
            err_exp_o  <= '0;
            err_got_o  <= '0;
        end else if (w_mis && r_err == 8'd0) begin
            err_addr_o <= BASE_ADDR + {22'd0, r_idx, 2'b00};
            err_exp_o  <= pattern(r_idx);
            err_got_o  <= rsp_data_i;
        end
    end
`endif
endmodule

// File: tb/tb_wb_traffic_gen.sv
// tb_wb_traffic_gen: directed bench for wb_traffic_gen with a memory-backed responder.
module tb_wb_traffic_gen;
    logic        clk_i = 1'b0, rstn_i = 1'b0, start_i = 1'b0;
    logic        busy_o, done_o, pass_o, timeout_o, req_valid_o, rsp_valid_i = 1'b0;
    logic [7:0]  err_cnt_o;
    logic [31:0] req_data_o, req_addr_o, rsp_data_i = '0;
    logic [2:0]  req_naccess_o;
    logic [3:0]  req_we_o;
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
    logic [31:0] err_addr_o, err_exp_o, err_got_o;
`endif
    int total = 0, bad = 0;
    logic        silent = 1'b0, rnd = 1'b0, spur = 1'b0;
    logic [15:0] bad_mask = '0;
    logic [31:0] mem [64];
    logic [31:0] wa [4], wd [4];
    int          wn = 0, vcnt;
    logic [31:0] exp_pat [4] = '{32'hACE1ACE1, 32'h4B19269A, 32'hE950A053, 32'h87881A0C};

    wb_traffic_gen dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_cnt_o(err_cnt_o), .timeout_o(timeout_o),
        .req_data_o(req_data_o), .req_addr_o(req_addr_o), .req_naccess_o(req_naccess_o),
        .req_we_o(req_we_o), .req_valid_o(req_valid_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i)
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
        , .err_addr_o(err_addr_o), .err_exp_o(err_exp_o), .err_got_o(err_got_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i) start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done_o; i++) @(negedge clk_i);
        chk("done", done_o, 1);
    endtask

    // Responder: answers each request after 0 (or random 0..10) cycles; may inject pulses between requests.
    initial begin
        logic        seen = 1'b0;
        int          dly = 0;
        logic [31:0] a = '0, d = '0;
        forever begin
            @(negedge clk_i);
            rsp_valid_i = 1'b0;
            if (req_valid_o && !silent) begin
                if (!seen) begin
                    seen = 1'b1;
                    dly  = rnd ? $urandom_range(0, 10) : 0;
                    a    = req_addr_o;
                    d    = req_data_o;
                end
                if (dly == 0) begin
                    chk("stable_addr", req_addr_o, a);
                    chk("stable_data", req_data_o, d);
                    chk("naccess", {29'd0, req_naccess_o}, 32'd4);
                    seen = 1'b0;
                    rsp_valid_i = 1'b1;
                    if (req_we_o == 4'hF) begin
                        mem[a[7:2]] = d;
                        rsp_data_i  = '0;
                        if (wn < 4) begin
                            wa[wn] = a;
                            wd[wn] = d;
                        end
                        wn++;
                    end else
                        rsp_data_i = bad_mask[a[5:2]] ? 32'hDEADBEEF : mem[a[7:2]];
                end else
                    dly--;
            end else begin
                seen = 1'b0;
                if (spur && $urandom_range(0, 1) == 1) begin
                    rsp_valid_i = 1'b1;
                    rsp_data_i  = $urandom;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_valid", req_valid_o, 0);
        chk("rst_addr", req_addr_o, 0);
        chk("rst_we", req_we_o, 0);
        rstn_i = 1'b1;
        // ideal responder
        pulse_start();
        chk("busy_run", busy_o, 1);
        wait_done(200);
        chk("pass1", pass_o, 1);
        chk("err1", err_cnt_o, 0);
        chk("tmo1", timeout_o, 0);
        chk("wcount", wn, 4);
        for (int i = 0; i < 4; i++) begin
            chk("waddr", wa[i], 32'(i * 4));
            chk("wdata", wd[i], exp_pat[i]);
        end
        chk("idle_valid", req_valid_o, 0);
        // corrupted readback of 0x8
        bad_mask = 16'h0004;
        pulse_start();
        wait_done(200);
        chk("err2", err_cnt_o, 1);
        chk("pass2", pass_o, 0);
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
        chk("log_addr", err_addr_o, 32'h8);
        chk("log_exp", err_exp_o, 32'hE950A053);
        chk("log_got", err_got_o, 32'hDEADBEEF);
`endif
        bad_mask = '0;
        // no response to the first write
        silent = 1'b1;
        vcnt = 0;
        pulse_start();
        vcnt = 1;
        for (int i = 0; i < 400 && !done_o; i++) begin
            @(negedge clk_i);
            if (req_valid_o) vcnt++;
        end
        chk("tmo_done", done_o, 1);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_pass", pass_o, 0);
        chk("tmo_valid", req_valid_o, 0);
        chk("tmo_cycles", vcnt, 255);
        silent = 1'b0;
        // random latency, spurious pulses, start while busy
        rnd = 1'b1;
        spur = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk_i);
        pulse_start();
        wait_done(2000);
        chk("pass_rnd", pass_o, 1);
        chk("err_rnd", err_cnt_o, 0);
        rnd = 1'b0;
        spur = 1'b0;
        // asynchronous reset in the read phase
        pulse_start();
        for (int i = 0; i < 200 && !(req_valid_o && req_we_o == 4'h0); i++) @(negedge clk_i);
        chk("in_read", req_valid_o && req_we_o == 4'h0, 1);
        @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_valid", req_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_addr", req_addr_o, 0);
        @(negedge clk_i) rstn_i = 1'b1;
        pulse_start();
        wait_done(200);
        chk("pass_after_rst", pass_o, 1);
        // three mismatches, then restart clears the count
        bad_mask = 16'h000B;
        pulse_start();
        wait_done(200);
        chk("err3", err_cnt_o, 3);
`ifdef WB_TRAFFIC_GEN_ERRLOG_EN
        chk("log_addr3", err_addr_o, 32'h0);
`endif
        bad_mask = '0;
        pulse_start();
        chk("err_clr", err_cnt_o, 0);
        chk("done_clr", done_o, 0);
        wait_done(200);
        chk("pass_last", pass_o, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
